// File: rtl/dmem_responder.sv
// Slow data-memory responder: one request in flight, response WAIT_STATES+1 edges after accept.
// Request side stalls (req_ready=0) until the response is taken; outputs hold while rsp_ready is low.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rd_word, wr_word, load_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          acc_err, mem_we;

  assign widx    = addr_q[AW+1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = mem_q[widx];

  // Any address bit above the storage span means out of range.
  assign acc_err = (size_q == 2'b11)
                 | ((size_q == 2'b01) & addr_q[0])
                 | ((size_q == 2'b10) & (|addr_q[1:0]))
                 | (|addr_q[31:AW+2]);

  always_comb begin
    byte_v    = rd_word[7:0];
    half_v    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    wr_word   = rd_word;
    case (lane)
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    case (size_q)
      2'b00: begin
        load_data = {{24{~uns_q & byte_v[7]}}, byte_v};
        wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = {{16{~uns_q & half_v[15]}}, half_v};
        if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      default: begin
        load_data = rd_word;
        wr_word   = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = acc_err;
          rdata_d = (acc_err | we_q) ? 32'h0 : load_data;
          mem_we  = we_q & ~acc_err;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  // Storage is never reset; a reset landing on the commit edge must suppress the write.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) mem_q[widx] <= wr_word;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule
